// File: rtl/chisq_best_sel.sv
// Chi-square output selector: forwards one channel by index (select mode) or
// scans the channels serially for the smallest value and its index (min mode).
module chisq_best_sel #(
  parameter int CHISQBITS = 32,
  parameter int NCH       = 4,
  parameter int SELBITS   = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [NCH*CHISQBITS-1:0] chisq_in,
  input  logic [NCH-1:0]           ovf_in,
  input  logic                     mode,
  input  logic [SELBITS-1:0]       sel,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [CHISQBITS-1:0]     chisq_out,
  output logic [SELBITS-1:0]       idx_out,
  output logic                     all_ovf,
  output logic [1:0]               state_dbg
);

  // Handshake: a transfer happens on a rising edge where valid && ready are
  // both high; in_ready is high only in IDLE, out_valid only in HOLD.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  localparam logic [CHISQBITS-1:0] SAT = {CHISQBITS{1'b1}};

  state_t                   r_state;
  state_t                   w_next;
  logic [NCH*CHISQBITS-1:0] r_chisq_cap;
  logic [NCH-1:0]           r_ovf_cap;
  logic [SELBITS-1:0]       r_cnt;
  logic [CHISQBITS-1:0]     r_best;
  logic [SELBITS-1:0]       r_idx;
  logic                     r_all_ovf;

  logic                     w_accept;
  logic                     w_scan_last;
  logic [CHISQBITS-1:0]     w_sel_eff;
  logic [SELBITS-1:0]       w_sel_idx;
  logic                     w_sel_ovf;
  logic [CHISQBITS-1:0]     w_scan_eff;
  logic                     w_scan_ovf;

  assign w_accept    = in_valid && (r_state == ST_IDLE);
  assign w_scan_last = (r_cnt == SELBITS'(NCH - 1));

  // Out-of-range sel matches no channel and falls back to channel 0.
  always_comb begin
    w_sel_idx = '0;
    w_sel_ovf = ovf_in[0];
    w_sel_eff = ovf_in[0] ? SAT : chisq_in[0 +: CHISQBITS];
    for (int k = 1; k < NCH; k++) begin
      if (sel == SELBITS'(k)) begin
        w_sel_idx = SELBITS'(k);
        w_sel_ovf = ovf_in[k];
        w_sel_eff = ovf_in[k] ? SAT : chisq_in[k*CHISQBITS +: CHISQBITS];
      end
    end
  end

  always_comb begin
    w_scan_ovf = r_ovf_cap[0];
    w_scan_eff = r_ovf_cap[0] ? SAT : r_chisq_cap[0 +: CHISQBITS];
    for (int k = 1; k < NCH; k++) begin
      if (r_cnt == SELBITS'(k)) begin
        w_scan_ovf = r_ovf_cap[k];
        w_scan_eff = r_ovf_cap[k] ? SAT : r_chisq_cap[k*CHISQBITS +: CHISQBITS];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (w_accept)    w_next = mode ? ST_SCAN : ST_HOLD;
      ST_SCAN: if (w_scan_last) w_next = ST_HOLD;
      ST_HOLD: if (out_ready)   w_next = ST_IDLE;
      default:                  w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (r_state == ST_IDLE);
    out_valid = (r_state == ST_HOLD);
    state_dbg = r_state;
  end

  // Ties never replace the current best, so the lowest index wins; an
  // all-overflow vector therefore reports channel 0 with the saturated value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_chisq_cap <= '0;
      r_ovf_cap   <= '0;
      r_cnt       <= '0;
      r_best      <= '0;
      r_idx       <= '0;
      r_all_ovf   <= 1'b0;
    end else if (w_accept) begin
      r_chisq_cap <= chisq_in;
      r_ovf_cap   <= ovf_in;
      r_cnt       <= '0;
      if (!mode) begin
        r_best    <= w_sel_eff;
        r_idx     <= w_sel_idx;
        r_all_ovf <= w_sel_ovf;
      end
    end else if (r_state == ST_SCAN) begin
      if ((r_cnt == '0) || (w_scan_eff < r_best)) begin
        r_best <= w_scan_eff;
        r_idx  <= r_cnt;
      end
      r_all_ovf <= (r_cnt == '0) ? w_scan_ovf : (r_all_ovf & w_scan_ovf);
      r_cnt     <= w_scan_last ? '0 : (r_cnt + SELBITS'(1));
    end
  end

  assign chisq_out = r_best;
  assign idx_out   = r_idx;
  assign all_ovf   = r_all_ovf;

endmodule

// File: tb/tb_chisq_best_sel.sv
// Directed bench for chisq_best_sel (NCH=4, CHISQBITS=32): expected results
// are queued at issue time and checked by an independent output monitor.
module tb_chisq_best_sel;

  localparam int W  = 32;
  localparam int N  = 4;
  localparam int SB = 2;
  localparam int EW = 1 + SB + W;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [N*W-1:0] chisq_in = '0;
  logic [N-1:0]   ovf_in = '0;
  logic           mode = 1'b0;
  logic [SB-1:0]  sel = '0;
  logic           out_valid;
  logic           out_ready = 1'b1;
  logic [W-1:0]   chisq_out;
  logic [SB-1:0]  idx_out;
  logic           all_ovf;
  logic [1:0]     state_dbg;

  logic [EW-1:0]  exp_q[$];
  int             checks = 0;
  int             failures = 0;

  chisq_best_sel #(.CHISQBITS(W), .NCH(N), .SELBITS(SB)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .chisq_in(chisq_in), .ovf_in(ovf_in),
    .mode(mode), .sel(sel),
    .out_valid(out_valid), .out_ready(out_ready),
    .chisq_out(chisq_out), .idx_out(idx_out), .all_ovf(all_ovf),
    .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, act, exp);
    end
  endtask

  // Monitor: every result transfer pops one expected entry.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_result", 64'({all_ovf, idx_out, chisq_out}), 64'hdead);
      end else begin
        logic [EW-1:0] e;
        e = exp_q.pop_front();
        check("result", 64'({all_ovf, idx_out, chisq_out}), 64'(e));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [N*W-1:0] pack4(input logic [W-1:0] c0, input logic [W-1:0] c1,
                                           input logic [W-1:0] c2, input logic [W-1:0] c3);
    return {c3, c2, c1, c0};
  endfunction

  task automatic push_exp(input logic [W-1:0] c, input logic [SB-1:0] i, input logic o);
    exp_q.push_back({o, i, c});
  endtask

  task automatic accept_vec(input logic m, input logic [SB-1:0] s,
                            input logic [N*W-1:0] v, input logic [N-1:0] o);
    int n;
    mode = m; sel = s; chisq_in = v; ovf_in = o; in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    if (!in_ready) check("accept_timeout", 64'(in_ready), 64'd1);
    tick();
    in_valid = 1'b0;
  endtask

  // Counts edges after the accept edge until out_valid is seen.
  task automatic wait_result(input int exp_lat);
    int lat;
    lat = 0;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
    check("latency", 64'(lat), 64'(exp_lat));
  endtask

  task automatic run(input logic m, input logic [SB-1:0] s, input logic [N*W-1:0] v,
                     input logic [N-1:0] o, input logic [W-1:0] ec,
                     input logic [SB-1:0] ei, input logic eo);
    push_exp(ec, ei, eo);
    accept_vec(m, s, v, o);
    wait_result(m ? N : 0);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) tick();
    rst = 1'b0;
    tick();
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_chisq_out", 64'(chisq_out), 64'd0);
    check("rst_idx_out",   64'(idx_out),   64'd0);
    check("rst_all_ovf",   64'(all_ovf),   64'd0);
    check("rst_in_ready",  64'(in_ready),  64'd1);

    run(1'b0, 2'd2, pack4(10, 20, 30, 40), 4'b0000, 32'd30, 2'd2, 1'b0);
    run(1'b0, 2'd1, pack4(10, 20, 30, 40), 4'b0010, 32'hFFFF_FFFF, 2'd1, 1'b1);
    run(1'b1, 2'd0, pack4(50, 7, 7, 90),   4'b0000, 32'd7, 2'd1, 1'b0);
    run(1'b1, 2'd3, pack4(5, 3, 9, 1),     4'b1010, 32'd5, 2'd0, 1'b0);
    run(1'b1, 2'd0, pack4(5, 3, 9, 1),     4'b1111, 32'hFFFF_FFFF, 2'd0, 1'b1);
    run(1'b1, 2'd0, pack4(8, 6, 4, 2),     4'b0000, 32'd2, 2'd3, 1'b0);

    // Back-pressure: stray vectors offered during SCAN and HOLD must be ignored.
    out_ready = 1'b0;
    push_exp(32'd3, 2'd2, 1'b0);
    accept_vec(1'b1, 2'd0, pack4(100, 200, 3, 300), 4'b0000);
    in_valid = 1'b1;
    chisq_in = pack4(1, 1, 1, 1);
    mode = 1'b0;
    check("scan_in_ready", 64'(in_ready), 64'd0);
    wait_result(N);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("hold_valid",    64'(out_valid), 64'd1);
      check("hold_chisq",    64'(chisq_out), 64'd3);
      check("hold_idx",      64'(idx_out),   64'd2);
      check("hold_in_ready", 64'(in_ready),  64'd0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    check("release_valid", 64'(out_valid), 64'd0);
    check("release_ready", 64'(in_ready),  64'd1);
    repeat (3) tick();
    check("no_extra_result", 64'(out_valid), 64'd0);

    // Asynchronous reset in the middle of a scan discards the operation.
    accept_vec(1'b1, 2'd0, pack4(4, 3, 2, 1), 4'b0000);
    tick();
    #2;
    rst = 1'b1;
    #1;
    check("abort_out_valid", 64'(out_valid), 64'd0);
    check("abort_chisq_out", 64'(chisq_out), 64'd0);
    check("abort_idx_out",   64'(idx_out),   64'd0);
    check("abort_all_ovf",   64'(all_ovf),   64'd0);
    check("abort_in_ready",  64'(in_ready),  64'd1);
    tick();
    rst = 1'b0;
    repeat (N + 2) tick();
    check("abort_no_result", 64'(out_valid), 64'd0);

    run(1'b0, 2'd3, pack4(11, 22, 33, 44), 4'b0000, 32'd44, 2'd3, 1'b0);

    repeat (2) tick();
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
